// File: rtl/mod_cntr_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package mod_cntr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Field width for values 0..v-1; never below one bit.
  function automatic int clog2c(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_cntr_sched_rr_arb.sv
// Combinational round-robin pick: first set request after i_last, wrapping.
module rr_arb
  import mod_cntr_sched_pkg::*;
#(
  parameter int R  = 4,
  parameter int LW = clog2c(R)
) (
  input  logic [R-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [R-1:0]  o_win,
  output logic [LW-1:0] o_idx
);

  always_comb begin
    int   j;
    logic found;
    o_win = '0;
    o_idx = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= R; k++) begin
      j = (int'(i_last) + k) % R;
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_win[j] = 1'b1;
        o_idx    = LW'(j);
      end
    end
  end

endmodule

// File: rtl/mod_cntr_sched.sv
// Shares one mod-N interval counter among R requesters in round-robin order.
module mod_cntr_sched
  import mod_cntr_sched_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 4,
  parameter int W = clog2c(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*W-1:0] len,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   cnt
);

  localparam int LW = clog2c(R);

  state_t        r_state;
  logic [R-1:0]  r_gnt;
  logic [R-1:0]  r_done;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  r_tgt;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_last;

  logic [R-1:0]  w_win;
  logic [LW-1:0] w_idx;
  logic          w_own_req;

  rr_arb #(.R(R), .LW(LW)) u_arb (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_idx  (w_idx)
  );

  assign w_own_req = req[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_idx   <= '0;
      r_last  <= LW'(R - 1);
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (|req) begin
            r_state <= RUN;
            r_gnt   <= w_win;
            r_idx   <= w_idx;
            r_tgt   <= len[w_idx*W +: W];
            r_cnt   <= '0;
          end
        end
        RUN: begin
          // A dropped request beats terminal count: abandon without done.
          if (!w_own_req) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_last  <= r_idx;
          end else if (r_cnt == r_tgt) begin
            r_state <= DONE;
            r_gnt   <= '0;
            r_done  <= r_gnt;
            r_cnt   <= '0;
            r_last  <= r_idx;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        DONE: begin
          r_done  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign busy = (r_state == RUN) || (r_state == DONE);

endmodule

// File: tb/tb_mod_cntr_sched.sv
// Bench for mod_cntr_sched: directed scenarios plus random traffic against a run-level model.
module tb_mod_cntr_sched;
  localparam int N = 32;
  localparam int R = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req = '0;
  logic [R*W-1:0] len = '0;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt;

  always #5 clk = ~clk;

  mod_cntr_sched #(.N(N), .R(R)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: who owns the counter, how far its run has got, and a pending done.
  int m_own   = -1;
  int m_el    = 0;
  int m_tg    = 0;
  int m_last  = R - 1;
  int m_dwho  = 0;
  bit m_dpend = 1'b0;
  int mj;

  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_el = 0; m_last = R - 1; m_dpend = 1'b0;
    end else if (m_dpend) begin
      m_dpend = 1'b0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_last = m_own; m_own = -1;
      end else if (m_el == m_tg) begin
        m_last = m_own; m_dwho = m_own; m_dpend = 1'b1; m_own = -1;
      end else begin
        m_el++;
      end
    end else if (req != 0) begin
      for (int k = 1; k <= R; k++) begin
        mj = (m_last + k) % R;
        if (m_own < 0 && req[mj]) begin
          m_own = mj; m_el = 0; m_tg = int'(len[mj*W +: W]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", int'(gnt), (m_own >= 0) ? (1 << m_own) : 0);
      check("done", int'(done), m_dpend ? (1 << m_dwho) : 0);
      check("busy", int'(busy), (m_own >= 0 || m_dpend) ? 1 : 0);
      check("cnt", int'(cnt), (m_own >= 0) ? m_el : 0);
      check("gnt_onehot0", int'($onehot0(gnt)), 1);
      check("done_gnt_overlap", int'(|(done & gnt)), 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic wait_cnt(input int v, input int budget);
    int c = 0;
    while (!(busy && int'(cnt) == v) && c < budget) begin tick(); c++; end
    check("wait_cnt", int'(cnt), v);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin tick(); c++; end
    check("wait_idle", int'(busy), 0);
  endtask

  int           rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int           order [$];
  logic [R-1:0] prev;
  int           mx, c, ri;

  initial begin
    // Reset held with all requesting: outputs stay clear.
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_en = 1'b1;
      check("rst_gnt", int'(gnt), 0);
      check("rst_done", int'(done), 0);
      check("rst_cnt", int'(cnt), 0);
      check("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    tick();
    check("first_gnt", int'(gnt), 1);
    req = '0;
    tick(); tick();

    // Single run, requester 2, len 5.
    set_len(2, 5);
    req = 4'b0100;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check("run_gnt", int'(gnt), 4);
      check("run_cnt", int'(cnt), i);
    end
    tick();
    check("run_done", int'(done), 4);
    check("run_gnt_off", int'(gnt), 0);
    req = '0;
    tick();
    check("run_busy_off", int'(busy), 0);

    // Round robin over 0,1,3 from a fresh pointer.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < R; i++) set_len(i, 3);
    req = 4'b1011;
    prev = '0; c = 0;
    while (order.size() < 6 && c < 200) begin
      tick(); c++;
      if (gnt != 0 && prev == 0) order.push_back($clog2(gnt));
      prev = gnt;
    end
    check("rr_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) check("rr_order", order[i], rr_exp[i]);
    req = '0;
    wait_idle(50);
    tick();

    // Abort at cnt 4 while requester 0 waits.
    set_len(1, 10);
    req = 4'b0010;
    wait_cnt(4, 20);
    req = 4'b0001;
    tick();
    check("abort_gnt", int'(gnt), 0);
    check("abort_done", int'(done), 0);
    tick();
    check("abort_regrant", int'(gnt), 1);
    req = '0;
    wait_idle(20);
    tick();

    // len = 0: one-cycle run.
    set_len(0, 0);
    req = 4'b0001;
    tick();
    check("len0_gnt", int'(gnt), 1);
    check("len0_cnt", int'(cnt), 0);
    tick();
    check("len0_done", int'(done), 1);
    check("len0_gnt_off", int'(gnt), 0);
    req = '0;
    tick();
    check("len0_busy_off", int'(busy), 0);

    // len = N-1: full 32-cycle run.
    set_len(0, N - 1);
    req = 4'b0001;
    for (int i = 0; i < N; i++) begin
      tick();
      check("full_cnt", int'(cnt), i);
    end
    tick();
    check("full_done", int'(done), 1);
    req = '0;
    tick(); tick();

    // Drop exactly at terminal count: no done.
    set_len(0, 4);
    req = 4'b0001;
    wait_cnt(4, 20);
    req = '0;
    tick();
    check("tc_drop_done", int'(done), 0);
    check("tc_drop_gnt", int'(gnt), 0);
    check("tc_drop_busy", int'(busy), 0);
    tick();

    // len change mid-run is ignored.
    set_len(3, 7);
    req = 4'b1000;
    tick();
    check("lenchg_gnt", int'(gnt), 8);
    set_len(3, 2);
    mx = 0; c = 0;
    while (done == 0 && c < 40) begin
      if (int'(cnt) > mx) mx = int'(cnt);
      tick(); c++;
    end
    check("lenchg_done", int'(done), 8);
    check("lenchg_max", mx, 7);
    req = '0;
    tick(); tick();

    // Reset mid-run: clears silently.
    set_len(3, 7);
    req = 4'b1000;
    wait_cnt(3, 20);
    rst = 1'b1;
    tick();
    check("mrst_gnt", int'(gnt), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_cnt", int'(cnt), 0);
    check("mrst_busy", int'(busy), 0);
    rst = 1'b0;
    req = '0;
    tick();
    check("mrst_no_done", int'(done), 0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(7) == 0) begin
        ri = int'($urandom_range(R - 1));
        req[ri] = ~req[ri];
      end
      ri = int'($urandom_range(R - 1));
      set_len(ri, int'($urandom_range(15)));
      rst = ($urandom_range(249) == 0);
    end
    rst = 1'b0;
    req = '0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/mod_cntr_sched.md
Name: mod_cntr_sched

Overview:
- Round-robin scheduler that shares one mod-N interval counter among R requesters.
- Each requester asks for a delay of len cycles. The scheduler grants the counter to one requester at a time, runs the count, and pulses that requester's done.
- Sits between timing clients (protocol timeouts, pacing logic) and the single counter resource, so each client does not need its own counter.

Parameters:
- N, 32, counter modulus; count values are 0..N-1.
- R, 4, number of requesters (R ≥ 2).
- W, $clog2(N), derived width of count and len fields; not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  R  level request per requester; held high until done or abandoned.
- len  in  R*W  packed per-requester terminal count; slice i is len[i*W +: W].
- gnt  out  R  one-hot grant; high for the whole run of the owning requester.
- done  out  R  one-cycle completion pulse to the owning requester.
- busy  out  1  high while the counter is owned (RUN or DONE state).
- cnt  out  W  live count value; 0 when idle.

Behaviour:
- Reset (sync, rst=1 at a clock edge) forces these values on the next cycle:
  - state=IDLE; gnt=0, done=0, busy=0, cnt=0.
  - Round-robin pointer last=R-1, so requester 0 has highest priority first.
- A reset mid-run abandons the run silently; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req≠0, select winner w = first set bit of req searching from (last+1) mod R upward with wrap.
  - Next cycle: gnt=onehot(w), tgt=len slice w (latched at this edge), cnt=0, state=RUN.
  - If req=0, stay in IDLE with all outputs 0.
- RUN:
  - cnt increments by 1 each cycle. cnt never exceeds N-1, because tgt ≤ N-1.
  - Completion: if cnt==tgt and req[w]=1 → state=DONE, gnt=0, done[w]=1 for exactly one cycle, last=w, cnt=0.
  - Abort: if req[w]=0 in any RUN cycle → state=IDLE next cycle, gnt=0, cnt=0, no done, last=w.
  - Abort and terminal count in the same cycle: abort wins, no done.
  - len changes during RUN are ignored; tgt is latched once per grant.
  - Requests from other requesters during RUN wait; they are never dropped or queued beyond their level req.
- DONE: one cycle; state=IDLE next cycle.
- Latency:
  - req sampled in IDLE at edge k → gnt high at cycle k+1.
  - gnt stays high for tgt+1 cycles, with cnt running 0..tgt.
  - done pulses at cycle k+tgt+2.
- len=0 gives a one-cycle run. len=N-1 gives a full N-cycle run.
- Back-to-back: after DONE, at least one IDLE cycle precedes the next grant, so the minimum gap is 2 cycles between runs.
- Fairness: a continuously requesting set of requesters is served in strict rotation. With all R requesting, each is granted once per R runs.
- Invariants: gnt is always zero or one-hot; done is one-hot or zero; done and gnt are never both high for the same index.

Decomposition:
- Package mod_cntr_sched_pkg holds:
  - the state enum/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper constant.
- Sub-module rr_arb (parameter R), purely combinational:
  - inputs req and last; output one-hot winner.
  - instantiated once.
- Counter, tgt latch and FSM stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 → gnt=0, done=0, cnt=0, busy=0 throughout. The first grant after rst drops goes to requester 0.
- Single run: req[2]=1, len2=5 from IDLE at edge k → gnt=4'b0100 at cycles k+1..k+6, cnt 0..5, done=4'b0100 only at k+7, busy low at k+8.
- Round robin: req=4'b1011 held with all len=3 → grant order 0,1,3,0,1,3. Each run is 4 cycles; every grant is separated by the DONE+IDLE gap.
- Abort: req[1]=1, len=10; drop req[1] when cnt=4 → gnt=0 next cycle, no done[1], last=1. A pending req[0] is granted after the IDLE cycle.
- Boundaries:
  - len=0 → gnt high for 1 cycle, done one cycle later.
  - len=N-1=31 → cnt reaches 31, never 0 mid-run, done after 32 counted cycles.
  - req dropped exactly at cnt==tgt → no done.
- Mid-run reset and len change: change len3 from 7 to 2 during the run → run still ends at cnt=7. Assert rst at cnt=3 → outputs clear next cycle, no done.
